// File: rtl/rll_keyed_xor_lane_if.sv
// Handshake bundle for the keyed XOR/XNOR lane: serial key loader plus gated data stream.
interface rll_keyed_xor_lane_if #(
  parameter int KEY_W = 32
);
  localparam int CW = $clog2(KEY_W + 1);

  logic             key_clr;
  logic             key_bit;
  logic             key_vld;
  logic             key_rdy;
  logic             armed;
  logic [CW-1:0]    key_cnt;
  logic [KEY_W-1:0] in_data;
  logic             in_vld;
  logic [KEY_W-1:0] out_data;
  logic             out_vld;

  modport master (
    output key_clr, key_bit, key_vld, in_data, in_vld,
    input  key_rdy, armed, key_cnt, out_data, out_vld
  );

  modport slave (
    input  key_clr, key_bit, key_vld, in_data, in_vld,
    output key_rdy, armed, key_cnt, out_data, out_vld
  );
endinterface

// File: rtl/rll_keyed_xor_lane.sv
// Serially loaded key register driving KEY_W XOR/XNOR key gates on a PIPE-stage data path.
// Transparent only when the loaded key equals POL_MASK.
module rll_keyed_xor_lane #(
  parameter int               KEY_W    = 32,
  parameter logic [KEY_W-1:0] POL_MASK = '0,
  parameter int               PIPE     = 1
) (
  input logic                  clk,
  input logic                  rst,
  rll_keyed_xor_lane_if.slave  bus
);
  localparam int CW = $clog2(KEY_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(KEY_W - 1);

  typedef enum logic [1:0] {EMPTY, LOAD, ARMED} state_t;

  state_t           state_reg, state_next;
  logic [KEY_W-1:0] key_reg, key_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [KEY_W:0]   key_cat;
  logic             armed_reg;
  logic             bit_take;
  logic             word_take;
  logic [KEY_W-1:0] gated;

  logic [PIPE-1:0]  stg_vld;
  logic [KEY_W-1:0] stg_data [PIPE];

  assign armed_reg = (state_reg == ARMED);
  // key_clr wins over a simultaneous key bit or data word.
  assign bit_take  = bus.key_vld && !armed_reg && !bus.key_clr;
  assign word_take = bus.in_vld && armed_reg && !bus.key_clr;
  assign key_cat   = {bus.key_bit, key_reg};
  assign gated     = bus.in_data ^ key_reg ^ POL_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      key_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    cnt_next   = cnt_reg;
    if (bus.key_clr) begin
      state_next = EMPTY;
      key_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        EMPTY, LOAD: begin
          if (bit_take) begin
            key_next   = key_cat[KEY_W:1];
            cnt_next   = cnt_reg + 1'b1;
            state_next = (cnt_reg == CNT_LAST) ? ARMED : LOAD;
          end
        end
        ARMED:   state_next = ARMED;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Each stage loads data only when a valid word moves in, so out_data holds between words.
  for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
    logic             vld_reg;
    logic [KEY_W-1:0] data_reg;
    logic             take;
    logic [KEY_W-1:0] din;

    if (gi == 0) begin : g_head
      assign take = word_take;
      assign din  = gated;
    end else begin : g_tail
      assign take = stg_vld[gi-1] && !bus.key_clr;
      assign din  = stg_data[gi-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_reg  <= 1'b0;
        data_reg <= '0;
      end else begin
        vld_reg <= take;
        if (take) data_reg <= din;
      end
    end

    assign stg_vld[gi]  = vld_reg;
    assign stg_data[gi] = data_reg;
  end

  assign bus.key_rdy  = !armed_reg;
  assign bus.armed    = armed_reg;
  assign bus.key_cnt  = cnt_reg;
  assign bus.out_vld  = stg_vld[PIPE-1];
  assign bus.out_data = stg_data[PIPE-1];
endmodule

// File: tb/tb_rll_keyed_xor_lane.sv
// Directed bench: PIPE=1 and PIPE=3 lanes share one stimulus stream, KEY_W=8, POL_MASK=8'hA5.
module tb_rll_keyed_xor_lane;
  logic clk = 1'b0;
  logic rst;
  logic key_clr, key_bit, key_vld, in_vld;
  logic [7:0] in_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rll_keyed_xor_lane_if #(.KEY_W(8)) if1 ();
  rll_keyed_xor_lane_if #(.KEY_W(8)) if3 ();

  assign if1.key_clr = key_clr;
  assign if1.key_bit = key_bit;
  assign if1.key_vld = key_vld;
  assign if1.in_data = in_data;
  assign if1.in_vld  = in_vld;
  assign if3.key_clr = key_clr;
  assign if3.key_bit = key_bit;
  assign if3.key_vld = key_vld;
  assign if3.in_data = in_data;
  assign if3.in_vld  = in_vld;

  rll_keyed_xor_lane #(.KEY_W(8), .POL_MASK(8'hA5), .PIPE(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  rll_keyed_xor_lane #(.KEY_W(8), .POL_MASK(8'hA5), .PIPE(3)) u3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
  );

  typedef struct {
    logic [7:0] key;
    logic [7:0] data;
    logic [7:0] expect_out;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_key();
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;
  endtask

  task automatic load_key(input logic [7:0] k, input int gap_after, input int gap_len);
    for (int i = 0; i < 8; i++) begin
      key_bit = k[i];
      key_vld = 1'b1;
      step();
      key_vld = 1'b0;
      if (i == 6) check("armed_before_last_bit", 32'(if1.armed), 32'd0);
      if (gap_len > 0 && i == gap_after - 1) begin
        repeat (gap_len) step();
        check("key_cnt_in_gap", 32'(if1.key_cnt), 32'(gap_after));
      end
    end
    check("key_cnt_full", 32'(if1.key_cnt), 32'd8);
    check("armed_after_load", 32'(if1.armed), 32'd1);
  endtask

  task automatic send_word(input logic [7:0] d, input logic [7:0] exp);
    in_data = d;
    in_vld  = 1'b1;
    step();
    in_vld  = 1'b0;
    check("word_out_vld", 32'(if1.out_vld), 32'd1);
    check("word_out_data", 32'(if1.out_data), 32'(exp));
    step();
    check("word_vld_drop", 32'(if1.out_vld), 32'd0);
    check("word_data_hold", 32'(if1.out_data), 32'(exp));
  endtask

  initial begin
    vecs[0] = '{key: 8'hA5, data: 8'h3C, expect_out: 8'h3C};
    vecs[1] = '{key: 8'h00, data: 8'h3C, expect_out: 8'h99};
    vecs[2] = '{key: 8'hFF, data: 8'h3C, expect_out: 8'h66};
    vecs[3] = '{key: 8'h5A, data: 8'h00, expect_out: 8'hFF};
    vecs[4] = '{key: 8'h12, data: 8'h34, expect_out: 8'h83};

    rst = 1'b1; key_clr = 1'b0; key_bit = 1'b0; key_vld = 1'b0;
    in_vld = 1'b0; in_data = 8'h00;
    repeat (2) step();
    check("rst_armed", 32'(if1.armed), 32'd0);
    check("rst_key_rdy", 32'(if1.key_rdy), 32'd1);
    check("rst_key_cnt", 32'(if1.key_cnt), 32'd0);
    check("rst_out_vld", 32'(if1.out_vld), 32'd0);
    check("rst_out_data", 32'(if1.out_data), 32'd0);
    check("rst_out_vld_p3", 32'(if3.out_vld), 32'd0);
    rst = 1'b0;

    // Key load with an idle gap after the fourth bit.
    load_key(8'hA5, 4, 3);
    check("key_rdy_armed", 32'(if1.key_rdy), 32'd0);
    send_word(8'h3C, 8'h3C);

    for (int v = 0; v < 5; v++) begin
      clear_key();
      load_key(vecs[v].key, 0, 0);
      send_word(vecs[v].data, vecs[v].expect_out);
    end

    // Words offered before the key is complete are dropped.
    clear_key();
    in_data = 8'h12;
    in_vld  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        key_bit = 1'b1;
        key_vld = 1'b1;
      end
      step();
      check("no_out_unarmed", 32'(if1.out_vld), 32'd0);
    end
    in_vld = 1'b0; key_vld = 1'b0;
    clear_key();
    load_key(8'h00, 0, 0);
    key_bit = 1'b1;
    key_vld = 1'b1;
    repeat (3) begin
      step();
      check("armed_cnt_hold", 32'(if1.key_cnt), 32'd8);
      check("armed_key_rdy", 32'(if1.key_rdy), 32'd0);
    end
    key_vld = 1'b0;
    send_word(8'h3C, 8'h99);

    // key_clr with simultaneous key_vld mid-load.
    clear_key();
    for (int i = 0; i < 4; i++) begin
      key_bit = 1'b1;
      key_vld = 1'b1;
      step();
    end
    check("partial_cnt", 32'(if1.key_cnt), 32'd4);
    key_clr = 1'b1;
    step();
    key_clr = 1'b0; key_vld = 1'b0;
    check("clr_cnt", 32'(if1.key_cnt), 32'd0);
    check("clr_armed", 32'(if1.armed), 32'd0);
    check("clr_key_rdy", 32'(if1.key_rdy), 32'd1);
    step();
    check("clr_cnt_idle", 32'(if1.key_cnt), 32'd0);
    load_key(8'h3C, 0, 0);
    send_word(8'h00, 8'h99);

    // Reset mid-load discards the partial key.
    clear_key();
    for (int i = 0; i < 3; i++) begin
      key_bit = 1'b1;
      key_vld = 1'b1;
      step();
    end
    key_vld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_cnt", 32'(if1.key_cnt), 32'd0);
    check("rst_mid_out_data", 32'(if1.out_data), 32'd0);
    load_key(8'hA5, 0, 0);
    send_word(8'h3C, 8'h3C);

    // PIPE=3 lane: latency, then flush of in-flight words. Key 0F -> gate mask AA.
    clear_key();
    load_key(8'h0F, 0, 0);
    in_data = 8'h11;
    in_vld  = 1'b1;
    step();
    in_vld = 1'b0;
    check("p3_lat1", 32'(if3.out_vld), 32'd0);
    step();
    check("p3_lat2", 32'(if3.out_vld), 32'd0);
    step();
    check("p3_lat3_vld", 32'(if3.out_vld), 32'd1);
    check("p3_lat3_data", 32'(if3.out_data), 32'h0BB);
    step();
    check("p3_after_vld", 32'(if3.out_vld), 32'd0);

    in_vld = 1'b1;
    in_data = 8'h01; step();
    check("p3_b2b_1", 32'(if3.out_vld), 32'd0);
    in_data = 8'h02; step();
    check("p3_b2b_2", 32'(if3.out_vld), 32'd0);
    in_data = 8'h03; step();
    check("p3_b2b_first_vld", 32'(if3.out_vld), 32'd1);
    check("p3_b2b_first_data", 32'(if3.out_data), 32'h0AB);
    in_vld  = 1'b0;
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;
    check("p3_flush_vld", 32'(if3.out_vld), 32'd0);
    check("p3_flush_armed", 32'(if3.armed), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("p3_flush_tail_vld", 32'(if3.out_vld), 32'd0);
      check("p3_flush_hold", 32'(if3.out_data), 32'h0AB);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
